// File: rtl/bram_read_scheduler.sv
// Round-robin burst read scheduler sharing one BRAM read port among NUM_REQ requesters.
// Issues one address per cycle and returns data tagged with requester ID and last-word flag.
module bram_read_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 20,
  parameter int unsigned DEPTH       = 13264,
  parameter int unsigned CLK_LATENCY = 1,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         bram_addrb,
  input  logic [DATA_WIDTH-1:0]     bram_dout,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_last,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      busy
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              issue;
  logic              issue_last;

  // Winner is the first pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign issue      = (state_q == StIssue);
  assign issue_last = issue && (remaining_q == '0);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          req_ready[win_id] = 1'b1;
          cur_addr_d        = req_addr[32'(win_id)*ADDR_W +: ADDR_W];
          remaining_d       = req_len[32'(win_id)*LEN_W +: LEN_W];
          cur_id_d          = win_id;
          rr_ptr_d          = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
          state_d           = StIssue;
        end
      end
      StIssue: begin
        last_addr_d = cur_addr_q;
        cur_addr_d  = (32'(cur_addr_q) == DEPTH - 1) ? '0 : cur_addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
    end
  end

  // Between bursts the port keeps presenting the last issued address.
  assign bram_addrb = issue ? cur_addr_q : last_addr_q;
  assign rsp_data   = bram_dout;

  if (CLK_LATENCY == 0) begin : g_comb
    assign rsp_valid = issue;
    assign rsp_id    = cur_id_q;
    assign rsp_last  = issue_last;
    assign busy      = issue;
  end else begin : g_pipe
    logic [CLK_LATENCY-1:0] vld_q;
    logic [CLK_LATENCY-1:0] last_q;
    logic [ID_W-1:0]        id_q [CLK_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= '0;
        last_q <= '0;
        for (int i = 0; i < int'(CLK_LATENCY); i++) id_q[i] <= '0;
      end else begin
        vld_q[0]  <= issue;
        last_q[0] <= issue_last;
        id_q[0]   <= cur_id_q;
        for (int i = 1; i < int'(CLK_LATENCY); i++) begin
          vld_q[i]  <= vld_q[i-1];
          last_q[i] <= last_q[i-1];
          id_q[i]   <= id_q[i-1];
        end
      end
    end

    assign rsp_valid = vld_q[CLK_LATENCY-1];
    assign rsp_id    = id_q[CLK_LATENCY-1];
    assign rsp_last  = last_q[CLK_LATENCY-1];
    assign busy      = issue | (|vld_q);
  end

endmodule

// File: tb/tb_bram_read_scheduler.sv
// Bench for bram_read_scheduler: three instances (read latency 0, 1, 2) share one request
// stimulus; each has its own BRAM model whose contents are a fixed function of the address.
module tb_bram_read_scheduler;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 20;
  localparam int unsigned DEPTH = 13264;
  localparam int unsigned AW    = 14;
  localparam int unsigned LW    = 8;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_len;

  logic [NR-1:0] ready [3];
  logic [AW-1:0] addrb [3];
  logic [DW-1:0] dout  [3];
  logic          rvld  [3];
  logic [1:0]    rid   [3];
  logic          rlast [3];
  logic [DW-1:0] rdata [3];
  logic          busy  [3];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_read_scheduler #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CLK_LATENCY(g),
      .LEN_W      (LW)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_ready (ready[g]),
      .bram_addrb(addrb[g]),
      .bram_dout (dout[g]),
      .rsp_valid (rvld[g]),
      .rsp_id    (rid[g]),
      .rsp_last  (rlast[g]),
      .rsp_data  (rdata[g]),
      .busy      (busy[g])
    );
  end

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return DW'(32'(a) * 32'd37 + 32'd5);
  endfunction

  logic [DW-1:0] d1_q, d2_q, d2b_q;
  always @(posedge clk) begin
    d1_q  <= mem_f(addrb[1]);
    d2_q  <= mem_f(addrb[2]);
    d2b_q <= d2_q;
  end
  assign dout[0] = mem_f(addrb[0]);
  assign dout[1] = d1_q;
  assign dout[2] = d2b_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input int l, input bit exp_v, input int exp_id, input bit exp_last,
                           input int exp_addr);
    check_eq($sformatf("rsp_valid L%0d", l), 32'(rvld[l]), 32'(exp_v));
    if (exp_v) begin
      check_eq($sformatf("rsp_id L%0d", l), 32'(rid[l]), exp_id);
      check_eq($sformatf("rsp_last L%0d", l), 32'(rlast[l]), 32'(exp_last));
      check_eq($sformatf("rsp_data L%0d", l), 32'(rdata[l]), 32'(mem_f(AW'(exp_addr))));
    end
  endtask

  // Called just after a rising edge with all instances idle.
  task automatic run_burst(input int id, input int addr, input int len);
    int k;
    bit v;
    req_valid                 = '0;
    req_valid[id]             = 1'b1;
    req_addr[id*AW +: AW]     = AW'(addr);
    req_len[id*LW +: LW]      = LW'(len);
    @(negedge clk);
    for (int l = 0; l < 3; l++) check_eq($sformatf("grant L%0d", l), 32'(ready[l]), 1 << id);
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 1; c <= len + 3; c++) begin
      @(negedge clk);
      if (c <= len + 1) begin
        check_eq("bram_addrb", 32'(addrb[1]), (addr + c - 1) % DEPTH);
        check_eq("busy issue", 32'(busy[1]), 1);
        check_eq("ready issue", 32'(ready[1]), 0);
      end
      for (int l = 0; l < 3; l++) begin
        k = c - 1 - l;
        v = (k >= 0) && (k <= len);
        check_rsp(l, v, id, k == len, (addr + k) % DEPTH);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check_eq("reset ready", 32'(ready[l]), 0);
      check_eq("reset addrb", 32'(addrb[l]), 0);
      check_eq("reset rsp_valid", 32'(rvld[l]), 0);
      check_eq("reset rsp_id", 32'(rid[l]), 0);
      check_eq("reset rsp_last", 32'(rlast[l]), 0);
      check_eq("reset busy", 32'(busy[l]), 0);
    end
    rst_n = 1'b1;

    // Single burst, then latency sweep, then address wrap.
    @(posedge clk); #1;
    run_burst(0, 10, 3);
    @(posedge clk); #1;
    run_burst(2, 100, 1);
    @(posedge clk); #1;
    run_burst(3, DEPTH - 2, 3);

    // Burst ending at 50, then ten idle cycles.
    @(posedge clk); #1;
    run_burst(1, 48, 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("idle addrb", 32'(addrb[1]), 50);
      check_eq("idle rsp_valid", 32'(rvld[1]), 0);
      check_eq("idle busy", 32'(busy[1]), 0);
    end

    // Reset during word 2 of a len=7 burst.
    @(posedge clk); #1;
    req_valid[0]      = 1'b1;
    req_addr[0 +: AW] = AW'(200);
    req_len[0 +: LW]  = LW'(7);
    @(negedge clk);
    check_eq("grant pre-reset", 32'(ready[1]), 1);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("word2 addrb", 32'(addrb[1]), 202);
    check_eq("word1 rsp_valid", 32'(rvld[1]), 1);
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < 3; l++) begin
      check_eq("async rsp_valid", 32'(rvld[l]), 0);
      check_eq("async busy", 32'(busy[l]), 0);
      check_eq("async ready", 32'(ready[l]), 0);
      check_eq("async addrb", 32'(addrb[l]), 0);
    end

    // Release with req0 and req1 pending, then all four continuously at len 0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) begin
      req_addr[i*AW +: AW] = AW'(300 + i);
      req_len[i*LW +: LW]  = '0;
    end
    req_valid = 4'b0011;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      if (c % 2 == 0) check_eq("rr grant", 32'(ready[1]), 1 << ((c / 2) % 4));
      else check_eq("rr grant gap", 32'(ready[1]), 0);
      check_rsp(1, (c >= 2) && (c % 2 == 0), (c / 2 + 3) % 4, 1'b1, 300 + (c / 2 + 3) % 4);
      if (c == 0) begin
        @(posedge clk);
        #1 req_valid = 4'b1111;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
